rx_prbs_ber_mon: RTL and testbench
==================================

Name: rx_prbs_ber_mon

Overview:
- Parametrised successor to the fixed PRBS23 checker plus error counter at the tail of the receive chain.
- Sits after DeFEC on clk_hh and consumes its byte stream (ival/idat).
- Adds run-time selectable polynomial, configurable data width, lock/unlock state machine, saturating counters and windowed BER measurement.
- Self-synchronising checker: no seed load is needed.

Parameters:
- DAT_W, 8, bits per input word (1..32).
- MSB_FIRST, 0: 1 means idat[DAT_W-1] is the earliest bit in time; 0 means idat[0] is earliest.
- ERR_W, 24, width of the total bit-error counter.
- WIN_W, 24, width of the window length and window error count.
- LOCK_CNT, 16, consecutive error-free words needed to declare lock.
- UNLOCK_THR, 2, a word with more error bits than this is "bad".
- UNLOCK_N, 4, consecutive bad words that cause loss of lock.

Ports:
- clk, in, 1, single clock for all logic.
- rst, in, 1, synchronous active-low reset.
- mode_in, in, 2, polynomial select: 0 PRBS7 x^7+x^6+1, 1 PRBS15 x^15+x^14+1, 2 PRBS23 x^23+x^18+1, 3 PRBS31 x^31+x^28+1.
- win_len, in, WIN_W, valid locked words per measurement window; 0 disables windows.
- iclr, in, 1, synchronous clear of counters and window state (active high).
- ival, in, 1, input word valid.
- idat, in, DAT_W, received data word.
- oval, out, 1, registered ival.
- oerr_bits, out, 6, popcount of the error mask for the word.
- lock, out, 1, checker locked.
- n_er, out, ERR_W, total error bits counted while locked (saturating).
- n_words, out, 32, valid words processed while locked (saturating).
- win_done, out, 1, one-cycle pulse at window end.
- win_err, out, WIN_W, error bits in the last completed window (held).

Behaviour:
- Reset (rst=0 at a clk edge): 31-bit history cleared to 0; FSM goes to HUNT. All outputs go to 0, including lock, n_er, n_words, win_err, oval and win_done.
- Bit processing, per valid word, in time order set by MSB_FIRST:
  - e = b XOR h[tapA] XOR h[tapB], where h is the previously received bits (h[1] = newest).
  - Taps per mode: (7,6), (15,14), (23,18), (31,28).
  - b is then shifted into h.
  - The whole word is processed combinationally in one cycle.
- History advances only on ival=1.
- Latency: word at cycle t gives oval, oerr_bits, lock and counter updates registered at t+1.
- oerr_bits is 0 whenever oval=0.
- One channel bit error produces 3 checker error bits. This is raw checker output; no correction is applied.
- FSM, HUNT:
  - good_cnt increments on each valid word with popcount=0.
  - good_cnt clears on any valid word with popcount>0.
  - When good_cnt reaches LOCK_CNT, go to LOCKED, set lock=1 and clear bad_cnt.
- FSM, LOCKED:
  - A valid word with popcount>UNLOCK_THR increments bad_cnt; any other valid word clears it.
  - When bad_cnt reaches UNLOCK_N, go to HUNT, set lock=0 and clear good_cnt.
- Counting: only while in LOCKED at the time the word is processed, including the word that causes unlock.
  - n_er += popcount.
  - n_words += 1.
  - Both saturate at all-ones and never wrap.
  - The word that completes lock is not counted.
- Window (win_len≠0):
  - Counts locked valid words and accumulates their error bits; the accumulator saturates at WIN_W all-ones.
  - When the word count equals win_len: win_done=1 for one cycle, win_err = accumulator including that word, then word count and accumulator clear.
  - Loss of lock clears the window word count and accumulator without a win_done pulse.
- mode_in change, detected by a registered compare:
  - FSM goes to HUNT and good_cnt, bad_cnt and the window clear.
  - History is kept; flush errors delay lock naturally.
  - n_er and n_words are held.
- iclr=1:
  - n_er, n_words, window count/accumulator and win_err clear on the next edge.
  - FSM and history are unaffected.
- iclr together with a valid locked word: the clear wins and that word is not counted.
- win_len is sampled each cycle. Lowering it below the current count ends the window at the next counted word (count ≥ win_len).

Test Plan:
- Reset: hold rst=0 for 5 cycles with ival toggling -> all outputs 0, lock=0; first edge after release still shows lock=0.
- Clean PRBS23 stream, mode_in=2, DAT_W=8, 1000 words -> lock=1 no later than word 20; n_er=0; n_words equals the words after lock.
- Flip one bit in a mid-stream word while locked -> oerr_bits totals 3 across the affected words, n_er=3, lock stays 1.
- win_len=100 with 2 isolated flips inside one window -> win_done pulses every 100 locked words; that window's win_err=6 and the next is 0.
- PRBS15 data with mode_in=2 -> lock never asserts and n_er=0. Then a locked PRBS31 stream with 4 random words (each popcount>2) -> lock drops 1 cycle after the 4th word and re-locks after the stream resumes.
- ERR_W=4, 6 flips while locked -> n_er saturates at 15; iclr pulse -> n_er=0 and win_err=0 the next cycle, lock unchanged.

Source files
------------

// File: rtl/rx_prbs_ber_mon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rx_prbs_ber_mon
// Purpose  : Self-synchronising PRBS checker with lock/unlock hunting,
//            saturating error/word totals and windowed BER measurement.
//            Polynomial is selectable at run time (PRBS7/15/23/31).
// Revision : 1.0 - initial release
// ============================================================================
module rx_prbs_ber_mon #(
    parameter int DAT_W      = 8,
    parameter int MSB_FIRST  = 0,
    parameter int ERR_W      = 24,
    parameter int WIN_W      = 24,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_THR = 2,
    parameter int UNLOCK_N   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic             iclr,
    input  logic             ival,
    input  logic [DAT_W-1:0] idat,
    output logic             oval,
    output logic [5:0]       oerr_bits,
    output logic             lock,
    output logic [ERR_W-1:0] n_er,
    output logic [31:0]      n_words,
    output logic             win_done,
    output logic [WIN_W-1:0] win_err
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_N + 1);
    localparam int ESUM_W = ERR_W + 7;
    localparam int WSUM_W = WIN_W + 7;

    localparam logic [GOOD_W-1:0] C_LOCK_CNT = GOOD_W'(LOCK_CNT);
    localparam logic [BAD_W-1:0]  C_UNLOCK_N = BAD_W'(UNLOCK_N);
    localparam logic [5:0]        C_THR      = 6'(UNLOCK_THR);
    localparam logic [ERR_W-1:0]  C_ERR_MAX  = '1;
    localparam logic [WIN_W-1:0]  C_WIN_MAX  = '1;

    typedef enum logic [0:0] {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t              state_q;
    logic [GOOD_W-1:0]   good_q;
    logic [BAD_W-1:0]    bad_q;
    logic                lock_q;
    logic [30:0]         hist_q;
    logic [30:0]         hist_d;
    logic [1:0]          mode_q;
    logic                oval_q;
    logic [5:0]          oerr_q;
    logic [ERR_W-1:0]    n_er_q;
    logic [31:0]         n_words_q;
    logic [WIN_W-1:0]    wcnt_q;
    logic [WIN_W-1:0]    wacc_q;
    logic [WIN_W-1:0]    win_err_q;
    logic                win_done_q;

    logic [DAT_W-1:0]    w_ord;
    logic [5:0]          err_pc;
    logic                mode_chg;
    logic                cnt_word;
    logic                word_bad;
    logic                unlock_now;
    logic [GOOD_W-1:0]   good_inc;
    logic [BAD_W-1:0]    bad_inc;
    logic [ESUM_W-1:0]   er_sum;
    logic [ERR_W-1:0]    n_er_nx;
    logic [31:0]         n_words_nx;
    logic [WIN_W-1:0]    wcnt_inc;
    logic [WSUM_W-1:0]   wacc_sum;
    logic [WIN_W-1:0]    wacc_nx;

    // Reorder the word so that w_ord[0] is always the earliest bit in time.
    for (genvar gi = 0; gi < DAT_W; gi++) begin : g_ord
        if (MSB_FIRST != 0) begin : g_msb
            assign w_ord[gi] = idat[DAT_W-1-gi];
        end else begin : g_lsb
            assign w_ord[gi] = idat[gi];
        end
    end

    // Walk the word bit by bit: compare against the recurrence, then shift the received bit in.
    always_comb begin
        logic [30:0] h;
        logic        b;
        logic        e;
        h      = hist_q;
        b      = 1'b0;
        e      = 1'b0;
        err_pc = '0;
        for (int i = 0; i < DAT_W; i++) begin
            b = w_ord[i];
            // h[0] holds the newest previous bit, so tap k lives at h[k-1].
            case (mode_in)
                2'd0:    e = b ^ h[6]  ^ h[5];
                2'd1:    e = b ^ h[14] ^ h[13];
                2'd2:    e = b ^ h[22] ^ h[17];
                default: e = b ^ h[30] ^ h[27];
            endcase
            err_pc = err_pc + {5'd0, e};
            h      = {h[29:0], b};
        end
        hist_d = ival ? h : hist_q;
    end

    assign mode_chg   = (mode_in != mode_q);
    assign cnt_word   = ival && (state_q == S_LOCKED) && !mode_chg;
    assign word_bad   = (err_pc > C_THR);
    assign good_inc   = good_q + 1'b1;
    assign bad_inc    = bad_q + 1'b1;
    assign unlock_now = cnt_word && word_bad && (bad_inc == C_UNLOCK_N);

    assign er_sum     = ESUM_W'(n_er_q) + ESUM_W'(err_pc);
    assign n_er_nx    = (er_sum > ESUM_W'(C_ERR_MAX)) ? C_ERR_MAX : er_sum[ERR_W-1:0];
    assign n_words_nx = (n_words_q == 32'hFFFF_FFFF) ? n_words_q : n_words_q + 32'd1;
    assign wcnt_inc   = wcnt_q + 1'b1;
    assign wacc_sum   = WSUM_W'(wacc_q) + WSUM_W'(err_pc);
    assign wacc_nx    = (wacc_sum > WSUM_W'(C_WIN_MAX)) ? C_WIN_MAX : wacc_sum[WIN_W-1:0];

    // History, mode tracking and per-word status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            mode_q <= 2'd0;
            oval_q <= 1'b0;
            oerr_q <= 6'd0;
        end else begin
            hist_q <= hist_d;
            mode_q <= mode_in;
            oval_q <= ival;
            oerr_q <= ival ? err_pc : 6'd0;
        end
    end

    // Lock hunting: LOCK_CNT clean words to lock, UNLOCK_N bad words to drop it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_HUNT;
            good_q  <= '0;
            bad_q   <= '0;
            lock_q  <= 1'b0;
        end else if (mode_chg) begin
            state_q <= S_HUNT;
            good_q  <= '0;
            bad_q   <= '0;
            lock_q  <= 1'b0;
        end else if (ival) begin
            case (state_q)
                S_HUNT: begin
                    if (err_pc == 6'd0) begin
                        if (good_inc == C_LOCK_CNT) begin
                            state_q <= S_LOCKED;
                            lock_q  <= 1'b1;
                            good_q  <= '0;
                            bad_q   <= '0;
                        end else begin
                            good_q <= good_inc;
                        end
                    end else begin
                        good_q <= '0;
                    end
                end
                default: begin
                    if (word_bad) begin
                        if (bad_inc == C_UNLOCK_N) begin
                            state_q <= S_HUNT;
                            lock_q  <= 1'b0;
                            good_q  <= '0;
                            bad_q   <= '0;
                        end else begin
                            bad_q <= bad_inc;
                        end
                    end else begin
                        bad_q <= '0;
                    end
                end
            endcase
        end
    end

    // Saturating totals and windowed error accumulation over locked words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_er_q     <= '0;
            n_words_q  <= '0;
            wcnt_q     <= '0;
            wacc_q     <= '0;
            win_err_q  <= '0;
            win_done_q <= 1'b0;
        end else begin
            win_done_q <= 1'b0;
            if (iclr) begin
                // Clear beats a coincident counted word.
                n_er_q    <= '0;
                n_words_q <= '0;
                wcnt_q    <= '0;
                wacc_q    <= '0;
                win_err_q <= '0;
            end else begin
                if (cnt_word) begin
                    n_er_q    <= n_er_nx;
                    n_words_q <= n_words_nx;
                end
                if (mode_chg || unlock_now) begin
                    // Abandon the partial window silently.
                    wcnt_q <= '0;
                    wacc_q <= '0;
                end else if (cnt_word && (win_len != '0)) begin
                    // ">=" so a shrunk win_len closes the window on the next word.
                    if (wcnt_inc >= win_len) begin
                        win_done_q <= 1'b1;
                        win_err_q  <= wacc_nx;
                        wcnt_q     <= '0;
                        wacc_q     <= '0;
                    end else begin
                        wcnt_q <= wcnt_inc;
                        wacc_q <= wacc_nx;
                    end
                end
            end
        end
    end

    assign oval      = oval_q;
    assign oerr_bits = oerr_q;
    assign lock      = lock_q;
    assign n_er      = n_er_q;
    assign n_words   = n_words_q;
    assign win_done  = win_done_q;
    assign win_err   = win_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_prbs_ber_mon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rx_prbs_ber_mon
// Purpose  : Randomised self-checking bench for rx_prbs_ber_mon, with a
//            bit-level reference model of the checker, FSM and counters.
//            A second instance with a 4-bit error counter exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_prbs_ber_mon;

    localparam int DAT_W = 8;
    localparam int WIN_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode_in;
    logic [WIN_W-1:0] win_len;
    logic             iclr;
    logic             ival;
    logic [DAT_W-1:0] idat;

    logic             a_oval,  b_oval;
    logic [5:0]       a_oerr,  b_oerr;
    logic             a_lock,  b_lock;
    logic [23:0]      a_ner;
    logic [3:0]       b_ner;
    logic [31:0]      a_nwords, b_nwords;
    logic             a_done,  b_done;
    logic [WIN_W-1:0] a_winerr, b_winerr;

    always #5 clk = ~clk;

    rx_prbs_ber_mon #(.DAT_W(DAT_W), .MSB_FIRST(0), .ERR_W(24), .WIN_W(WIN_W)) u_dut_a (
        .clk(clk), .rst(rst), .mode_in(mode_in), .win_len(win_len), .iclr(iclr),
        .ival(ival), .idat(idat), .oval(a_oval), .oerr_bits(a_oerr), .lock(a_lock),
        .n_er(a_ner), .n_words(a_nwords), .win_done(a_done), .win_err(a_winerr)
    );

    rx_prbs_ber_mon #(.DAT_W(DAT_W), .MSB_FIRST(0), .ERR_W(4), .WIN_W(WIN_W)) u_dut_b (
        .clk(clk), .rst(rst), .mode_in(mode_in), .win_len(win_len), .iclr(iclr),
        .ival(ival), .idat(idat), .oval(b_oval), .oerr_bits(b_oerr), .lock(b_lock),
        .n_er(b_ner), .n_words(b_nwords), .win_done(b_done), .win_err(b_winerr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         mh[$];          // received-bit history, index 0 = most recent
    bit         m_lock;
    int         m_good, m_bad;
    logic [1:0] m_mode_prev;
    longint     m_ner, m_nwords, m_wcnt, m_wacc, m_winerr;
    bit         m_oval, m_done;
    int         m_oerr;

    function automatic int tap_a(input logic [1:0] m);
        case (m)
            2'd0:    return 7;
            2'd1:    return 15;
            2'd2:    return 23;
            default: return 31;
        endcase
    endfunction

    function automatic int tap_b(input logic [1:0] m);
        case (m)
            2'd0:    return 6;
            2'd1:    return 14;
            2'd2:    return 18;
            default: return 28;
        endcase
    endfunction

    function automatic longint satw(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Error bits for one word; optionally commits the word into the history.
    function automatic int word_errs(input logic [7:0] d, input logic [1:0] m, input bit commit);
        bit h[$];
        int pc;
        h  = mh;
        pc = 0;
        for (int i = 0; i < DAT_W; i++) begin
            bit b;
            b  = d[i];
            pc += int'(b ^ h[tap_a(m)-1] ^ h[tap_b(m)-1]);
            h.push_front(b);
            void'(h.pop_back());
        end
        if (commit) mh = h;
        return pc;
    endfunction

    task automatic model_step(input bit v, input logic [7:0] d, input bit clr);
        int pc;
        bit chg, was_locked, unlocked;
        if (rst == 1'b0) begin
            mh = {};
            for (int i = 0; i < 31; i++) mh.push_back(1'b0);
            m_lock = 0; m_good = 0; m_bad = 0; m_mode_prev = 2'd0;
            m_ner = 0; m_nwords = 0; m_wcnt = 0; m_wacc = 0; m_winerr = 0;
            m_oval = 0; m_oerr = 0; m_done = 0;
        end else begin
            pc          = v ? word_errs(d, mode_in, 1'b1) : 0;
            chg         = (mode_in != m_mode_prev);
            m_mode_prev = mode_in;
            m_oval      = v;
            m_oerr      = pc;
            m_done      = 0;
            was_locked  = m_lock;
            unlocked    = 0;
            if (chg) begin
                m_lock = 0; m_good = 0; m_bad = 0;
            end else if (v) begin
                if (!m_lock) begin
                    m_good = (pc == 0) ? m_good + 1 : 0;
                    if (m_good == 16) begin m_lock = 1; m_good = 0; m_bad = 0; end
                end else begin
                    m_bad = (pc > 2) ? m_bad + 1 : 0;
                    if (m_bad == 4) begin m_lock = 0; m_good = 0; m_bad = 0; unlocked = 1; end
                end
            end
            if (clr) begin
                m_ner = 0; m_nwords = 0; m_wcnt = 0; m_wacc = 0; m_winerr = 0;
            end else begin
                if (v && was_locked && !chg) begin
                    m_ner    += pc;
                    m_nwords += 1;
                end
                if (chg || unlocked) begin
                    m_wcnt = 0; m_wacc = 0;
                end else if (v && was_locked && win_len != 0) begin
                    m_wcnt += 1;
                    m_wacc = satw(m_wacc + pc, WIN_W);
                    if (m_wcnt >= longint'(win_len)) begin
                        m_done = 1; m_winerr = m_wacc; m_wcnt = 0; m_wacc = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("oval",      a_oval,   m_oval);
        chk("oerr_bits", a_oerr,   m_oerr);
        chk("lock",      a_lock,   m_lock);
        chk("n_er",      a_ner,    satw(m_ner, 24));
        chk("n_words",   a_nwords, satw(m_nwords, 32));
        chk("win_done",  a_done,   m_done);
        chk("win_err",   a_winerr, m_winerr);
        chk("b_oval",    b_oval,   m_oval);
        chk("b_oerr",    b_oerr,   m_oerr);
        chk("b_lock",    b_lock,   m_lock);
        chk("b_n_er",    b_ner,    satw(m_ner, 4));
        chk("b_n_words", b_nwords, satw(m_nwords, 32));
        chk("b_win_done", b_done,  m_done);
        chk("b_win_err", b_winerr, m_winerr);
    endtask

    // ---------------- stimulus generator ----------------
    bit gq[$];
    int g_a, g_b;

    task automatic gen_seed(input int a, input int b);
        gq = {};
        for (int i = 0; i < 31; i++) gq.push_back(bit'($urandom_range(0, 1)));
        gq[0] = 1'b1;
        g_a = a;
        g_b = b;
    endtask

    function automatic logic [7:0] next_word();
        logic [7:0] w;
        bit nb;
        w = 8'd0;
        for (int i = 0; i < DAT_W; i++) begin
            nb = gq[g_a-1] ^ gq[g_b-1];
            gq.push_front(nb);
            void'(gq.pop_back());
            w[i] = nb;
        end
        return w;
    endfunction

    // One clock: drive, let the edge pass, update model, compare everything.
    task automatic step(input bit v, input logic [7:0] d, input bit clr);
        ival = v;
        idat = d;
        iclr = clr;
        @(posedge clk);
        #1;
        model_step(v, d, clr);
        compare_all();
        ival = 1'b0;
        iclr = 1'b0;
    endtask

    // Valid word, optionally preceded by a random idle cycle.
    task automatic send(input logic [7:0] d);
        if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0);
        step(1'b1, d, 1'b0);
    endtask

    function automatic logic [7:0] flip_mask();
        return 8'(1 << $urandom_range(0, 7));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int         lock_at, sum, k, nd, seen, tries;
        int         done_k[3];
        longint     done_err[3];
        logic [7:0] d;

        rst = 1'b0; mode_in = 2'd2; win_len = '0; iclr = 1'b0; ival = 1'b0; idat = '0;

        // Reset with ival toggling.
        for (int i = 0; i < 5; i++) step(bit'(i % 2), 8'($urandom), 1'b0);
        chk("rst_lock", a_lock, 0);
        chk("rst_n_er", a_ner, 0);
        chk("rst_oval", a_oval, 0);
        rst = 1'b1;
        step(1'b0, 8'd0, 1'b0);
        chk("rel_lock", a_lock, 0);

        // Clean PRBS23 stream.
        gen_seed(23, 18);
        lock_at = 0;
        for (int w = 1; w <= 1000; w++) begin
            send(next_word());
            if (w == 20) chk("lock_by_20", a_lock, 1);
            if (m_lock && lock_at == 0) lock_at = w;
        end
        chk("p23_n_er", a_ner, 0);
        chk("p23_n_words", a_nwords, 64'(1000 - lock_at));

        // Single channel bit flip -> three checker error bits.
        sum = 0;
        send(next_word() ^ flip_mask());
        sum += int'(a_oerr);
        for (int i = 0; i < 6; i++) begin
            send(next_word());
            sum += int'(a_oerr);
        end
        chk("flip_oerr_sum", 64'(sum), 3);
        chk("flip_n_er", a_ner, 3);
        chk("flip_lock", a_lock, 1);

        // Windows of 100 words, two flips in the second window.
        step(1'b0, 8'd0, 1'b1);
        win_len = 24'd100;
        k = 0; nd = 0;
        for (int w = 0; w < 400 && nd < 3; w++) begin
            d = next_word();
            k++;
            if (k == 130 || k == 170) d = d ^ flip_mask();
            send(d);
            if (a_done) begin
                if (nd < 3) begin done_k[nd] = k; done_err[nd] = longint'(a_winerr); end
                nd++;
            end
        end
        chk("win_count", 64'(nd), 3);
        for (int i = 0; i < 3; i++) chk("win_pos", 64'(done_k[i]), 64'(100 * (i + 1)));
        chk("win0_err", done_err[0], 0);
        chk("win1_err", done_err[1], 6);
        chk("win2_err", done_err[2], 0);
        for (int i = 0; i < 50; i++) send(next_word());
        win_len = 24'd30;
        send(next_word());
        chk("win_lowered", a_done, 1);
        win_len = '0;

        // PRBS15 data against the PRBS23 checker.
        gen_seed(15, 14);
        for (int w = 0; w < 40 && m_lock; w++) send(next_word());
        chk("p15_unlock", a_lock, 0);
        step(1'b0, 8'd0, 1'b1);
        seen = 0;
        for (int w = 0; w < 200; w++) begin
            send(next_word());
            if (a_lock) seen = 1;
        end
        chk("p15_nolock", 64'(seen), 0);
        chk("p15_n_er", a_ner, 0);

        // PRBS31: lock, four bad words, relock.
        mode_in = 2'd3;
        gen_seed(31, 28);
        for (int w = 0; w < 60 && !m_lock; w++) send(next_word());
        chk("p31_lock", a_lock, 1);
        for (int j = 0; j < 4; j++) begin
            tries = 0;
            d = 8'($urandom);
            while (word_errs(d, 2'd3, 1'b0) <= 2 && tries < 200) begin
                d = 8'($urandom);
                tries++;
            end
            step(1'b1, d, 1'b0);
            if (j == 2) chk("bad3_lock", a_lock, 1);
            if (j == 3) chk("bad4_unlock", a_lock, 0);
        end
        for (int w = 0; w < 80 && !m_lock; w++) send(next_word());
        chk("p31_relock", a_lock, 1);

        // Saturation of the narrow counter, then clear.
        win_len = 24'd20;
        step(1'b0, 8'd0, 1'b1);
        for (int f = 0; f < 6; f++) begin
            send(next_word() ^ flip_mask());
            for (int i = 0; i < 9; i++) send(next_word());
        end
        chk("sat_a_n_er", a_ner, 18);
        chk("sat_b_n_er", b_ner, 15);
        chk("sat_lock", a_lock, 1);
        step(1'b0, 8'd0, 1'b1);
        chk("clr_b_n_er", b_ner, 0);
        chk("clr_a_n_er", a_ner, 0);
        chk("clr_win_err", a_winerr, 0);
        chk("clr_lock", a_lock, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
